// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencing controller: drives PC freeze/select, handshakes with a
// variable-latency instruction memory and feeds IF/ID through a registered slot plus hold buffer.
module if_fetch_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_freeze,
  output logic            pc_sel,
  output logic [XLEN-1:0] redirect_addr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_addr,
  input  logic            hazard_stall,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] hold_pc_q, hold_pc_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            slot_free;

  assign slot_free = !if_valid_q || !hazard_stall;

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    if_valid_d    = if_valid_q && hazard_stall;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    hold_pc_d     = hold_pc_q;
    hold_instr_d  = hold_instr_q;
    fetch_count_d = fetch_count_q;
    pc_freeze     = 1'b1;
    pc_sel        = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        // A redirect seen while idle still steers the first request.
        if (branch_taken) begin
          pc_freeze = 1'b0;
          pc_sel    = 1'b1;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          pc_freeze = 1'b0;
          if (branch_taken) begin
            pc_sel = 1'b1;
          end else if (slot_free) begin
            if_valid_d    = 1'b1;
            if_pc_d       = pc;
            if_instr_d    = mem_rdata;
            fetch_count_d = fetch_count_q + 32'd1;
          end else begin
            hold_pc_d    = pc;
            hold_instr_d = mem_rdata;
            state_d      = HOLD;
          end
        end else if (branch_taken) begin
          target_d = branch_addr;
          state_d  = DRAIN;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_freeze = 1'b0;
          pc_sel    = 1'b1;
          state_d   = FETCH;
        end else if (!hazard_stall) begin
          if_valid_d    = 1'b1;
          if_pc_d       = hold_pc_q;
          if_instr_d    = hold_instr_q;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = FETCH;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          target_d = branch_addr;
        end
        if (mem_ready) begin
          pc_freeze = 1'b0;
          pc_sel    = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect flushes the slot regardless of hazard_stall.
    if (branch_taken) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      target_q      <= '0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      hold_pc_q     <= '0;
      hold_instr_q  <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      hold_pc_q     <= hold_pc_d;
      hold_instr_q  <= hold_instr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign redirect_addr = branch_taken ? branch_addr : target_q;
  assign mem_req       = (state_q == FETCH) || (state_q == DRAIN);
  assign mem_addr      = pc;
  assign if_valid      = if_valid_q;
  assign if_pc         = if_pc_q;
  assign if_instr      = if_instr_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: PC register and memory are modelled here, deliveries are
// checked by a monitor popping a scoreboard of hand-computed expected instructions.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_freeze;
  logic        pc_sel;
  logic [31:0] redirect_addr;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        hazard_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] count;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_count = '0;
  logic        nf, ns;
  logic [31:0] nr;

  if_fetch_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_freeze(pc_freeze), .pc_sel(pc_sel),
    .redirect_addr(redirect_addr), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .hazard_stall(hazard_stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], 16'h0013} ^ 32'h00A5_0000;
  endfunction

  assign mem_rdata = instr_of(pc);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] cnt);
    exp_t e;
    e.pc    = p;
    e.instr = instr_of(p);
    e.count = cnt;
    sb.push_back(e);
  endtask

  // Next-PC controls sampled mid-cycle, applied just after the edge by tick().
  always @(negedge clk) begin
    nf = pc_freeze;
    ns = pc_sel;
    nr = redirect_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) pc = '0;
    else if (!nf) pc = ns ? nr : pc + 32'd4;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_count = fetch_count;
    end else if (fetch_count != last_count) begin
      last_count = fetch_count;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got pc %h count %h expected none", if_pc, fetch_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("slot_valid", {31'd0, if_valid}, 32'd1);
        chk("slot_pc", if_pc, e.pc);
        chk("slot_instr", if_instr, e.instr);
        chk("slot_count", fetch_count, e.count);
      end
    end
  end

  initial begin
    rst = 1'b1; pc = '0; mem_ready = 1'b0;
    branch_taken = 1'b0; branch_addr = '0; hazard_stall = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_pc_freeze", {31'd0, pc_freeze}, 32'd1);
    chk("rst_pc_sel", {31'd0, pc_sel}, 32'd0);
    chk("rst_redirect", redirect_addr, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    tick();

    // C0: IDLE for one cycle after reset release
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    chk("idle_freeze", {31'd0, pc_freeze}, 32'd1);
    tick();

    // C1..C8: zero-wait streaming
    for (int k = 0; k < 8; k++) begin
      mem_ready = 1'b1;
      push(32'(k * 4), 32'(k + 1));
      @(negedge clk);
      chk("stream_mem_req", {31'd0, mem_req}, 32'd1);
      chk("stream_addr", mem_addr, 32'(k * 4));
      chk("stream_freeze", {31'd0, pc_freeze}, 32'd0);
      tick();
    end

    // C9: last streamed instruction visible
    mem_ready = 1'b0;
    @(negedge clk);
    chk("stream_count", fetch_count, 32'd8);
    chk("stream_last_pc", if_pc, 32'h1C);
    tick();

    // C10..C12: three wait cycles
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_freeze", {31'd0, pc_freeze}, 32'd1);
      chk("wait_addr", mem_addr, 32'h20);
      chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
      chk("wait_valid", {31'd0, if_valid}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    push(32'h20, 32'd9);
    tick();

    // C14: response arrives while slot stalled -> HOLD
    hazard_stall = 1'b1;
    push(32'h24, 32'd10);
    @(negedge clk);
    chk("hold_entry_pc", if_pc, 32'h20);
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_slot_pc", if_pc, 32'h20);
      chk("hold_slot_valid", {31'd0, if_valid}, 32'd1);
      chk("hold_mem_req", {31'd0, mem_req}, 32'd0);
      chk("hold_freeze", {31'd0, pc_freeze}, 32'd1);
      chk("hold_count", fetch_count, 32'd9);
      tick();
    end
    hazard_stall = 1'b0;
    @(negedge clk);
    chk("release_count", fetch_count, 32'd9);
    tick();

    // C19: branch while fetch in flight -> DRAIN
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    @(negedge clk);
    chk("midbr_freeze", {31'd0, pc_freeze}, 32'd1);
    chk("midbr_addr", mem_addr, 32'h28);
    tick();
    branch_addr = 32'h200;
    @(negedge clk);
    chk("drain_redirect", redirect_addr, 32'h200);
    chk("drain_mem_req", {31'd0, mem_req}, 32'd1);
    chk("drain_addr", mem_addr, 32'h28);
    chk("drain_valid", {31'd0, if_valid}, 32'd0);
    tick();
    branch_taken = 1'b0;
    mem_ready    = 1'b1;
    @(negedge clk);
    chk("drain_done_freeze", {31'd0, pc_freeze}, 32'd0);
    chk("drain_done_sel", {31'd0, pc_sel}, 32'd1);
    chk("drain_done_redirect", redirect_addr, 32'h200);
    chk("drain_done_valid", {31'd0, if_valid}, 32'd0);
    tick();

    // C22: redirect coinciding with a ready response in FETCH
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    @(negedge clk);
    chk("target_addr", mem_addr, 32'h200);
    chk("fbr_sel", {31'd0, pc_sel}, 32'd1);
    chk("fbr_valid", {31'd0, if_valid}, 32'd0);
    tick();
    branch_taken = 1'b0;
    push(32'h300, 32'd11);
    @(negedge clk);
    chk("fbr_target_addr", mem_addr, 32'h300);
    chk("fbr_valid_after", {31'd0, if_valid}, 32'd0);
    tick();

    // C24: stall into HOLD, then asynchronous reset mid-HOLD
    hazard_stall = 1'b1;
    @(negedge clk);
    chk("pre_rst_count", fetch_count, 32'd11);
    chk("pre_rst_pc", if_pc, 32'h300);
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("rst_hold_mem_req", {31'd0, mem_req}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_freeze", {31'd0, pc_freeze}, 32'd1);
    chk("async_sel", {31'd0, pc_sel}, 32'd0);
    chk("async_redirect", redirect_addr, 32'd0);
    chk("async_valid", {31'd0, if_valid}, 32'd0);
    chk("async_if_pc", if_pc, 32'd0);
    chk("async_if_instr", if_instr, 32'd0);
    chk("async_count", fetch_count, 32'd0);
    hazard_stall = 1'b0;
    tick();
    tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

- Sequencing controller for the instruction-fetch stage.
- Drives the PC register's `freeze` and next-PC mux select, and runs a valid/ready handshake with a variable-latency instruction memory.
- Presents fetched instructions to IF/ID through a registered output slot with a one-entry hold buffer.
- Handles EX-stage branch redirects, including redirects that arrive while a memory access is in flight.

## Interface
- `XLEN`, 32, width of PC, addresses and instructions
- `clk` input 1: system clock, rising edge
- `rst` input 1: reset, asynchronous, active-high
- `pc` input XLEN: current PC register value
- `pc_freeze` output 1: 1 = PC register holds
- `pc_sel` output 1: 0 = PC+4, 1 = `redirect_addr`
- `redirect_addr` output XLEN: branch target driven to the next-PC mux
- `branch_taken` input 1: single-cycle redirect pulse from EX
- `branch_addr` input XLEN: target, valid with `branch_taken`
- `hazard_stall` input 1: IF/ID does not consume the output slot this cycle
- `mem_req` output 1: instruction-memory request
- `mem_addr` output XLEN: request address
- `mem_ready` input 1: response valid this cycle
- `mem_rdata` input XLEN: instruction, valid with `mem_ready`
- `if_valid` output 1: output slot holds a live instruction
- `if_pc` output XLEN: PC of the slot instruction
- `if_instr` output XLEN: slot instruction
- `fetch_count` output 32: count of instructions delivered to the slot; wraps at 2^32

## Operation
- **States:** IDLE, FETCH, HOLD, DRAIN.
- **Memory protocol:**
  - `mem_addr` = `pc`, and stays stable while `mem_req`=1.
  - `mem_req` drops only after the `mem_ready` cycle.
  - A transaction cannot be aborted.
  - `mem_req` = 1 in FETCH and DRAIN, 0 otherwise.
- **Slot free:** `!if_valid || !hazard_stall`.
- **IDLE:** unconditionally goes to FETCH next cycle. `pc_freeze`=1.
- **FETCH, no `mem_ready`:**
  - `pc_freeze`=1.
  - `branch_taken` latches `branch_addr` into the saved target and moves to DRAIN.
- **FETCH, `mem_ready`, `branch_taken`:**
  - Response discarded.
  - `pc_freeze`=0, `pc_sel`=1, `redirect_addr`=`branch_addr`.
  - Stays FETCH.
- **FETCH, `mem_ready`, slot free:**
  - Slot ← (`pc`, `mem_rdata`), `if_valid`←1, `fetch_count`+1.
  - `pc_freeze`=0, `pc_sel`=0.
  - Stays FETCH.
- **FETCH, `mem_ready`, slot not free:**
  - Hold buffer ← (`pc`, `mem_rdata`).
  - `pc_freeze`=0, `pc_sel`=0.
  - Goes to HOLD.
- **HOLD:**
  - `pc_freeze`=1.
  - When `!hazard_stall`: slot ← hold buffer, `fetch_count`+1, go to FETCH.
  - `branch_taken` here: hold buffer dropped, `pc_freeze`=0, `pc_sel`=1, `redirect_addr`=`branch_addr`, go to FETCH.
- **DRAIN:**
  - Waits for the in-flight response, then discards it.
  - A new `branch_taken` overwrites the saved target; the newest target wins.
  - On `mem_ready`: `pc_freeze`=0, `pc_sel`=1, `redirect_addr`=saved target, go to FETCH.
  - If `branch_taken` coincides with that `mem_ready`, `branch_addr` is used.
- **Slot rules:**
  - `branch_taken` in any state clears `if_valid` next cycle and overrides `hazard_stall`.
  - If the slot is consumed (`if_valid && !hazard_stall`) with no new fill, `if_valid`←0.
  - With `hazard_stall`=1, the slot contents hold.
- **Default outputs:**
  - `redirect_addr` = `branch_addr` when `branch_taken`, else the saved target.
  - `pc_sel`=0 unless stated above.
- **Reset:** async assertion forces IDLE from any state, including mid-transaction. The outstanding memory transaction is abandoned; memory must tolerate this.

## Timing
- **Reset values:**
  - State IDLE.
  - `mem_req`=0, `pc_freeze`=1, `pc_sel`=0.
  - `redirect_addr`=0, saved target=0.
  - `if_valid`=0, `if_pc`=0, `if_instr`=0.
  - Hold buffer=0, `fetch_count`=0.
- **Startup:** first `mem_req` in the 2nd rising edge after `rst` deasserts (IDLE lasts one cycle).
- **Latency:** `mem_ready` in cycle N gives `if_valid`/`if_instr` at cycle N+1. The PC updates at the end of N, and `mem_req` stays 1 with the new address in N+1.
- **Throughput:** zero-wait memory (`mem_ready` tied 1) delivers 1 instruction/cycle.
- **Registers:** `pc_freeze`, `pc_sel` and `redirect_addr` are combinational from state and inputs. Slot, hold buffer and counter are registered.
- **Branch to fetch:** `branch_taken` at cycle B (FETCH with ready, HOLD, or IDLE) gives `mem_addr`=target at B+1. From FETCH without ready, the target is requested the cycle after the in-flight `mem_ready`.

## Test plan
- **Reset/startup:** `rst` 1→0, `pc`=0x0, `mem_ready`=1 → `mem_req` rises the cycle after IDLE; `if_valid` follows 1 cycle later with `if_pc`=0x0, `fetch_count`=1.
- **Streaming:** zero-wait memory, 8 cycles, PC stepping by 4 → `if_pc` 0x0,0x4,…,0x1C on consecutive cycles; `fetch_count`=8.
- **Variable latency:** `mem_ready` after 3 wait cycles → `pc_freeze`=1 for 3 cycles, `mem_addr` stable, `if_valid`=0 during the wait.
- **Stall/hold:** `hazard_stall`=1 for 4 cycles with the slot full while a response returns → HOLD entered; slot unchanged; on release, held instruction appears next cycle and no instruction is lost or duplicated.
- **Mid-fetch branch:** `branch_taken` with `branch_addr`=0x100 two cycles before `mem_ready`, then a second branch to 0x200 in DRAIN → response discarded, `redirect_addr`=0x200, next `mem_addr`=0x200, `if_valid`=0 throughout.
- **Reset mid-HOLD:** assert `rst` during HOLD → all outputs at reset values immediately, without waiting for a clock edge.
